decoder: RTL and testbench
==========================

# decoder

Instruction control decoder for the pico-MIPS processor core. It takes the 6-bit opcode of the current instruction and the ALU zero flag, and drives the datapath control signals: ALU function, register write, immediate select, multiplier select, input-port read, output-port write and PC-relative branch. It sits between instruction memory and the datapath. Outputs are combinational, so they are valid in the same cycle the instruction is presented.

## Interface
Parameters: none. Opcode and ALU codes come from the shared `opcodes.sv` and `alucodes.sv` definitions.

- clk  input  1  system clock; one clock domain; no sequential state in this block
- rst  input  1  asynchronous, active-high reset; one clock; forces all outputs low while high
- opcode  input  6  instruction opcode
- ZF  input  1  ALU zero flag from the current instruction's ALU result
- alu_func  output  3  ALU operation select
- reg_write  output  1  register-file write enable
- immediate  output  1  ALU operand B selects the immediate field
- mult  output  1  write-back source is the multiplier result
- read_in  output  1  write-back source is the external input port
- write_out  output  1  latch register data onto the external output port
- pc_rel_branch  output  1  next PC = PC + signed offset

## Operation
- Opcode encodings (6-bit): NOP 000000, ADD 000001, SUB 000010, ADDI 000011, SUBI 000100, BEQ 000101, BNQ 000110, JMP 000111, MULT 001000, STIN 001001, LOUT 001010.
- ALU codes (3-bit): RNOP 000, RADD 001, RSUB 010.
- Default for every opcode: all 1-bit outputs 0 and alu_func = RNOP. Each opcode overrides only the fields listed below.
- ADD: alu_func = RADD, reg_write = 1.
- SUB: alu_func = RSUB, reg_write = 1.
- ADDI: alu_func = RADD, immediate = 1, reg_write = 1.
- SUBI: alu_func = RSUB, immediate = 1, reg_write = 1.
- BEQ: alu_func = RSUB (compare), pc_rel_branch = ZF, reg_write = 0.
- BNQ: alu_func = RSUB, pc_rel_branch = !ZF, reg_write = 0.
- JMP: pc_rel_branch = 1 unconditionally; ZF is ignored.
- MULT: mult = 1, reg_write = 1.
- STIN: read_in = 1, reg_write = 1.
- LOUT: write_out = 1, reg_write = 0.
- NOP and any unlisted opcode (001011 to 111111): all outputs at their defaults; never any write or branch.
- mult and read_in are never asserted together.
- ZF affects only pc_rel_branch, and only for BEQ and BNQ.
- X or Z on opcode is decoded as an unlisted opcode (all outputs at defaults).

## Timing
- Purely combinational from opcode, ZF and rst to all outputs; latency 0 cycles.
- Outputs must be settled well before the next rising clk edge, because the datapath samples them at that edge.
- rst = 1: all outputs go to 0 (alu_func = 000) immediately, independent of clk.
- On rst deassertion, outputs follow opcode and ZF without waiting for a clock edge.
- No internal state. clk is unused functionally and exists only for interface uniformity.
- A ZF change during a BEQ or BNQ propagates to pc_rel_branch in the same cycle.

## Test plan
- ADD, then SUB, one per cycle, with rst = 0 -> alu_func = 001 then 010; reg_write = 1; immediate = mult = read_in = write_out = pc_rel_branch = 0.
- ADDI, then SUBI -> alu_func = 001 then 010; immediate = 1; reg_write = 1.
- BEQ with ZF = 0 then ZF = 1 -> pc_rel_branch = 0 then 1. BNQ with ZF = 1 then ZF = 0 -> pc_rel_branch = 0 then 1. reg_write = 0 throughout.
- JMP with ZF = 0 and ZF = 1 -> pc_rel_branch = 1 both times; all other outputs at defaults.
- MULT -> mult = 1, reg_write = 1. STIN -> read_in = 1, reg_write = 1. LOUT -> write_out = 1, reg_write = 0.
- Opcode 111111 -> all outputs 0. Any opcode (e.g. ADD) with rst = 1 -> all outputs 0; releasing rst restores ADD decode with no clock edge.

Source files
------------

// File: rtl/decoder.sv
// pico-MIPS instruction control decoder: maps opcode and ALU zero flag onto datapath
// control lines. Purely combinational; rst forces every output low without a clock.
module decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       ZF,
    output logic [2:0] alu_func,
    output logic       reg_write,
    output logic       immediate,
    output logic       mult,
    output logic       read_in,
    output logic       write_out,
    output logic       pc_rel_branch
);

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_ADD  = 6'b000001;
    localparam logic [5:0] OP_SUB  = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_SUBI = 6'b000100;
    localparam logic [5:0] OP_BEQ  = 6'b000101;
    localparam logic [5:0] OP_BNQ  = 6'b000110;
    localparam logic [5:0] OP_JMP  = 6'b000111;
    localparam logic [5:0] OP_MULT = 6'b001000;
    localparam logic [5:0] OP_STIN = 6'b001001;
    localparam logic [5:0] OP_LOUT = 6'b001010;

    localparam logic [2:0] RNOP = 3'b000;
    localparam logic [2:0] RADD = 3'b001;
    localparam logic [2:0] RSUB = 3'b010;

    // clk exists only for interface uniformity; the decode has no state.
    logic unused_clk_s;
    assign unused_clk_s = clk;

    // Opcode decode; unlisted and X/Z opcodes fall through to the all-zero default.
    always_comb begin
        alu_func      = RNOP;
        reg_write     = 1'b0;
        immediate     = 1'b0;
        mult          = 1'b0;
        read_in       = 1'b0;
        write_out     = 1'b0;
        pc_rel_branch = 1'b0;
        if (rst) begin
            alu_func      = RNOP;
            pc_rel_branch = 1'b0;
        end else begin
            case (opcode)
                OP_NOP: begin
                    alu_func = RNOP;
                end
                OP_ADD: begin
                    alu_func  = RADD;
                    reg_write = 1'b1;
                end
                OP_SUB: begin
                    alu_func  = RSUB;
                    reg_write = 1'b1;
                end
                OP_ADDI: begin
                    alu_func  = RADD;
                    immediate = 1'b1;
                    reg_write = 1'b1;
                end
                OP_SUBI: begin
                    alu_func  = RSUB;
                    immediate = 1'b1;
                    reg_write = 1'b1;
                end
                OP_BEQ: begin
                    alu_func      = RSUB;
                    pc_rel_branch = ZF;
                end
                OP_BNQ: begin
                    alu_func      = RSUB;
                    pc_rel_branch = ~ZF;
                end
                OP_JMP: begin
                    pc_rel_branch = 1'b1;
                end
                OP_MULT: begin
                    mult      = 1'b1;
                    reg_write = 1'b1;
                end
                OP_STIN: begin
                    read_in   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_LOUT: begin
                    write_out = 1'b1;
                end
                default: begin
                    alu_func = RNOP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: expected control words are queued as stimulus is
// applied and popped when the outputs are sampled mid-cycle.
module tb_decoder;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       ZF;
    logic [2:0] alu_func;
    logic       reg_write;
    logic       immediate;
    logic       mult;
    logic       read_in;
    logic       write_out;
    logic       pc_rel_branch;

    int compared;
    int mismatched;
    logic [8:0] exp_q[$];

    decoder dut (
        .clk(clk),
        .rst(rst),
        .opcode(opcode),
        .ZF(ZF),
        .alu_func(alu_func),
        .reg_write(reg_write),
        .immediate(immediate),
        .mult(mult),
        .read_in(read_in),
        .write_out(write_out),
        .pc_rel_branch(pc_rel_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // word layout: {alu_func, reg_write, immediate, mult, read_in, write_out, pc_rel_branch}
    function automatic logic [8:0] observed();
        return {alu_func, reg_write, immediate, mult, read_in, write_out, pc_rel_branch};
    endfunction

    task automatic drive(input logic [5:0] op, input logic zf, input logic [8:0] expv);
        @(posedge clk);
        #1;
        opcode = op;
        ZF     = zf;
        exp_q.push_back(expv);
    endtask

    task automatic test_reset();
        logic [8:0] expv;
        rst = 1'b1; opcode = 6'b000001; ZF = 1'b1;
        exp_q.push_back(9'b000000000);
        @(negedge clk);
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL reset_add got=%b exp=%b", observed(), expv);
        end
        // release in mid-cycle: ADD decode must appear with no clock edge
        rst = 1'b0;
        exp_q.push_back(9'b001100000);
        #1;
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL reset_release got=%b exp=%b", observed(), expv);
        end
        rst = 1'b1;
        exp_q.push_back(9'b000000000);
        #1;
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL reset_async got=%b exp=%b", observed(), expv);
        end
        rst = 1'b0;
    endtask

    task automatic test_arith();
        logic [5:0] ops [4] = '{6'b000001, 6'b000010, 6'b000011, 6'b000100};
        logic [8:0] exps[4] = '{9'b001100000, 9'b010100000, 9'b001110000, 9'b010110000};
        logic [8:0] expv;
        for (int i = 0; i < 4; i++) begin
            drive(ops[i], i[0], exps[i]);
            @(negedge clk);
            expv = exp_q.pop_front();
            compared++;
            if (observed() !== expv) begin
                mismatched++;
                $display("FAIL arith op=%b got=%b exp=%b", ops[i], observed(), expv);
            end
        end
    endtask

    task automatic test_branch();
        logic [5:0] ops [6] = '{6'b000101, 6'b000101, 6'b000110, 6'b000110, 6'b000111, 6'b000111};
        logic       zfs [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [8:0] exps[6] = '{9'b010000000, 9'b010000001, 9'b010000000,
                                9'b010000001, 9'b000000001, 9'b000000001};
        logic [8:0] expv;
        for (int i = 0; i < 6; i++) begin
            drive(ops[i], zfs[i], exps[i]);
            @(negedge clk);
            expv = exp_q.pop_front();
            compared++;
            if (observed() !== expv) begin
                mismatched++;
                $display("FAIL branch op=%b zf=%b got=%b exp=%b", ops[i], zfs[i], observed(), expv);
            end
        end
        // ZF toggles within a BEQ cycle and must propagate at once
        ZF = 1'b0; opcode = 6'b000101;
        exp_q.push_back(9'b010000000);
        #1;
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL beq_zf_toggle got=%b exp=%b", observed(), expv);
        end
    endtask

    task automatic test_io_mult();
        logic [5:0] ops [3] = '{6'b001000, 6'b001001, 6'b001010};
        logic [8:0] exps[3] = '{9'b000101000, 9'b000100100, 9'b000000010};
        logic [8:0] expv;
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], 1'b1, exps[i]);
            @(negedge clk);
            expv = exp_q.pop_front();
            compared++;
            if (observed() !== expv) begin
                mismatched++;
                $display("FAIL io_mult op=%b got=%b exp=%b", ops[i], observed(), expv);
            end
        end
    endtask

    task automatic test_unlisted();
        logic [8:0] expv;
        for (int op = 6'd11; op <= 6'd63; op++) begin
            drive(op[5:0], op[0], 9'b000000000);
            @(negedge clk);
            expv = exp_q.pop_front();
            compared++;
            if (observed() !== expv) begin
                mismatched++;
                $display("FAIL unlisted op=%b got=%b exp=%b", op[5:0], observed(), expv);
            end
        end
        drive(6'b000000, 1'b1, 9'b000000000);
        @(negedge clk);
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL nop got=%b exp=%b", observed(), expv);
        end
        drive(6'bxxxxxx, 1'b1, 9'b000000000);
        @(negedge clk);
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL x_opcode got=%b exp=%b", observed(), expv);
        end
    endtask

    task automatic test_back_to_back();
        logic [8:0] expv;
        drive(6'b000001, 1'b0, 9'b001100000);
        @(negedge clk);
        drive(6'b001001, 1'b0, 9'b000100100);
        @(negedge clk);
        drive(6'b000110, 1'b0, 9'b010000001);
        @(negedge clk);
        // drain in order; sample lags stimulus only for the last entry
        while (exp_q.size() > 1) begin
            void'(exp_q.pop_front());
        end
        expv = exp_q.pop_front();
        compared++;
        if (observed() !== expv) begin
            mismatched++;
            $display("FAIL back_to_back got=%b exp=%b", observed(), expv);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_arith();
        test_branch();
        test_io_mult();
        test_unlisted();
        test_back_to_back();
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
